// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control.
// Optional two's-complement overflow output when CSA_PIPE_OVF_EN is defined.
module csa_pipe_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned BLK   = 4,
   parameter int unsigned BPS   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef CSA_PIPE_OVF_EN
   output logic             ovf,
`endif
   output logic [WIDTH-1:0] S,
   output logic             Cout
);

   localparam int unsigned NBLK = WIDTH / BLK;
   localparam int unsigned LAT  = (NBLK + BPS - 1) / BPS;

   logic [LAT-1:0] vld;
   logic [LAT-1:0] rdy;

   // A stage can load if any stage at or after it is empty, or the consumer pops.
   always_comb begin
      logic all_full;
      all_full = 1'b1;
      rdy      = '0;
      for (int k = LAT - 1; k >= 0; k--) begin
         all_full = all_full & vld[k];
         rdy[k]   = out_ready | ~all_full;
      end
   end

   assign in_ready = rdy[0];

   for (genvar k = 0; k < LAT; k++) begin : g_stage
      localparam int unsigned Lo = k * BPS;
      localparam int unsigned Hi = ((k + 1) * BPS < NBLK) ? (k + 1) * BPS : NBLK;

      logic             v_in;
      logic [WIDTH-1:0] a_in, b_in, s_in, s_d;
      logic             c_in, c_d;
      logic             vld_q;
      logic [WIDTH-1:0] s_q;
      logic             c_q;

      if (k == 0) begin : g_first
         assign v_in = in_valid;
         assign a_in = A;
         assign b_in = B ^ {WIDTH{sub}};
         assign c_in = sub | Cin;
         assign s_in = '0;
      end else begin : g_next
         assign v_in = g_stage[k-1].vld_q;
         assign a_in = g_stage[k-1].g_ab.a_q;
         assign b_in = g_stage[k-1].g_ab.b_q;
         assign c_in = g_stage[k-1].c_q;
         assign s_in = g_stage[k-1].s_q;
      end

      // Each block forms both carry hypotheses, then the incoming carry selects.
      always_comb begin
         logic [BLK:0] r0, r1;
         logic         c;
         s_d = s_in;
         c   = c_in;
         r0  = '0;
         r1  = '0;
         for (int unsigned j = Lo; j < Hi; j++) begin
            r0 = {1'b0, a_in[j*BLK +: BLK]} + {1'b0, b_in[j*BLK +: BLK]};
            r1 = {1'b0, a_in[j*BLK +: BLK]} + {1'b0, b_in[j*BLK +: BLK]} + (BLK+1)'(1);
            s_d[j*BLK +: BLK] = c ? r1[BLK-1:0] : r0[BLK-1:0];
            c = c ? r1[BLK] : r0[BLK];
         end
         c_d = c;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            s_q   <= '0;
            c_q   <= 1'b0;
         end else if (rdy[k]) begin
            vld_q <= v_in;
            if (v_in) begin
               s_q <= s_d;
               c_q <= c_d;
            end
         end
      end

      assign vld[k] = vld_q;

      if (k < LAT - 1) begin : g_ab
         logic [WIDTH-1:0] a_q, b_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (rdy[k] && v_in) begin
               a_q <= a_in;
               b_q <= b_in;
            end
         end
      end

`ifdef CSA_PIPE_OVF_EN
      if (k == LAT - 1) begin : g_ovf
         logic ovf_q;
         // Carry into the MSB is recovered from the MSB sum bit and its operands.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (rdy[k] && v_in) begin
               ovf_q <= a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ s_d[WIDTH-1] ^ c_d;
            end
         end
      end
`endif
   end

   assign out_valid = g_stage[LAT-1].vld_q;
   assign S         = g_stage[LAT-1].s_q;
   assign Cout      = g_stage[LAT-1].c_q;
`ifdef CSA_PIPE_OVF_EN
   assign ovf       = g_stage[LAT-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Directed bench for csa_pipe_adder at default parameters (latency 4).
// Checks ovf as well when CSA_PIPE_OVF_EN is defined.
module tb_csa_pipe_adder;

   localparam int LAT = 4;

   logic        clk, rst_n, in_valid, in_ready, Cin, sub, out_valid, out_ready, Cout;
   logic [15:0] A, B, S;
`ifdef CSA_PIPE_OVF_EN
   logic        ovf;
`endif

   int errors = 0;
   int checks = 0;

   csa_pipe_adder #(.WIDTH(16), .BLK(4), .BPS(1)) dut (
`ifdef CSA_PIPE_OVF_EN
      .ovf      (ovf),
`endif
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .A        (A),
      .B        (B),
      .Cin      (Cin),
      .sub      (sub),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .S        (S),
      .Cout     (Cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a, b;
      logic        cin, sub;
      logic [15:0] s;
      logic        c, o;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(input logic [15:0] a, b, input logic cin, sb,
                               input logic [15:0] s, input logic c, o);
      vec_t v;
      v.a = a; v.b = b; v.cin = cin; v.sub = sb; v.s = s; v.c = c; v.o = o;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int cyc;
      @(negedge clk);
      chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
      A = v.a; B = v.b; Cin = v.cin; sub = v.sub; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk({nm, "_latency"}, 32'(cyc), 32'(LAT));
      chk({nm, "_S"}, 32'(S), 32'(v.s));
      chk({nm, "_Cout"}, 32'(Cout), 32'(v.c));
`ifdef CSA_PIPE_OVF_EN
      chk({nm, "_ovf"}, 32'(ovf), 32'(v.o));
`endif
      @(negedge clk);
      chk({nm, "_bubble_valid"}, 32'(out_valid), 32'd0);
      chk({nm, "_S_hold"}, 32'(S), 32'(v.s));
   endtask

   initial begin
      int got, first, last, acc, stale;
      vec_t v;

      vecs[0]  = mk(16'hABCD, 16'hFFFF, 1'b0, 1'b0, 16'hABCC, 1'b1, 1'b0);
      vecs[1]  = mk(16'hABCD, 16'hFFFF, 1'b1, 1'b0, 16'hABCD, 1'b1, 1'b0);
      vecs[2]  = mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      vecs[3]  = mk(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
      vecs[4]  = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      vecs[5]  = mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      vecs[6]  = mk(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
      vecs[7]  = mk(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
      vecs[8]  = mk(16'h0008, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0);
      vecs[9]  = mk(16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
      vecs[10] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      vecs[11] = mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      A = '0; B = '0; Cin = 1'b0; sub = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_S", 32'(S), 32'd0);
      chk("rst_Cout", 32'(Cout), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed vectors
      for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Back-to-back stream of 8 ops
      got = 0; first = -1; last = -1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (out_valid) begin
            if (got < 8) chk($sformatf("b2b_S%0d", got), 32'(S), 32'(16'h1001 * got));
            if (first < 0) first = c;
            last = c;
            got++;
         end
         if (c < 8) begin
            chk($sformatf("b2b_in_ready%0d", c), 32'(in_ready), 32'd1);
            A = 16'(c); B = 16'(c * 4096); Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
      end
      chk("b2b_count", 32'(got), 32'd8);
      chk("b2b_first", 32'(first), 32'(LAT));
      chk("b2b_span", 32'(last - first), 32'd7);

      // Stall with out_ready low for 6 cycles
      out_ready = 1'b0; acc = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c >= 4) begin
            chk($sformatf("stall_valid%0d", c), 32'(out_valid), 32'd1);
            chk($sformatf("stall_S%0d", c), 32'(S), 32'h0100);
         end
         if (in_ready) begin
            A = 16'(16'h0100 + acc); B = 16'(acc); Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            acc++;
         end else begin
            in_valid = 1'b0;
         end
      end
      chk("stall_accepted", 32'(acc), 32'd4);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) @(negedge clk);
         if (out_valid) begin
            if (got < 4) chk($sformatf("drain_S%0d", got), 32'(S), 32'(16'h0100 + 2 * got));
            got++;
         end
      end
      chk("drain_count", 32'(got), 32'd4);
      run_vec(mk(16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0), "post_stall");

      // Reset with two ops in flight
      @(negedge clk);
      A = 16'h1111; B = 16'h0001; in_valid = 1'b1;
      @(negedge clk);
      A = 16'h2222;
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_S", 32'(S), 32'd0);
      chk("midrst_Cout", 32'(Cout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      v = mk(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
      run_vec(v, "post_rst");
      stale = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      chk("post_rst_stale", 32'(stale), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
